// File: rtl/demux_pkg.sv
// Shared types for the 1-to-4 stream demultiplexer.
// Port select type, output count and holding-register state encoding.
package demux_pkg;

    localparam int NUM_OUT = 4;

    typedef logic [1:0] port_sel_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } demux_state_t;

    function automatic logic [NUM_OUT-1:0] sel_onehot(input port_sel_t sel);
        logic [NUM_OUT-1:0] v;
        v = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/sat_cnt_v1.sv
// Saturating up-counter with enable; sticks at all-ones, never wraps.
// Ports: clk, rst_n (async active-low), en_i (count), cnt_o (value).
module sat_cnt_v1 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/demux4_stream_v1.sv
// Registered 1-to-4 valid/ready stream demux, single-entry buffer.
// Ports: clk, rst_n, in_valid/in_ready/in_data/in_sel (upstream),
// out_valid/out_ready/out_data (four consumers), busy (buffer full),
// cnt_out (per-port saturating transfer counters, only with DEMUX_CNT_EN).
module demux4_stream_v1
    import demux_pkg::*;
#(
    parameter int width     = 32,
    parameter int cnt_width = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [width-1:0]       in_data,
    input  logic [1:0]             in_sel,
    output logic [NUM_OUT-1:0]     out_valid,
    input  logic [NUM_OUT-1:0]     out_ready,
    output logic [width-1:0]       out_data,
    output logic                   busy
`ifdef DEMUX_CNT_EN
    ,
    output logic [4*cnt_width-1:0] cnt_out
`endif
);

    demux_state_t state_q, state_d;
    logic [width-1:0] data_q, data_d;
    port_sel_t        sel_q, sel_d;

    logic in_xfer;
    logic out_xfer;

    // in_ready in FULL follows the selected consumer combinationally,
    // which is what allows back-to-back beats.
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            EMPTY:   in_ready = rst_n;
            FULL:    in_ready = rst_n & out_ready[sel_q];
            default: in_ready = 1'b0;
        endcase
    end

    assign out_valid = (state_q == FULL) ? sel_onehot(sel_q) : '0;
    assign out_data  = data_q;
    assign busy      = (state_q == FULL);

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = |(out_valid & out_ready);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = FULL;
                    data_d  = in_data;
                    sel_d   = in_sel;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    if (in_xfer) begin
                        data_d = in_data;
                        sel_d  = in_sel;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

`ifdef DEMUX_CNT_EN
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_cnt
        sat_cnt_v1 #(
            .W(cnt_width)
        ) u_cnt (
            .clk  (clk),
            .rst_n(rst_n),
            .en_i (out_valid[k] & out_ready[k]),
            .cnt_o(cnt_out[k*cnt_width +: cnt_width])
        );
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (cnt_width > 0);
`endif

endmodule

// File: tb/tb_demux4_stream_v1.sv
// Self-checking bench for demux4_stream_v1: queue scoreboard plus
// directed vectors; counter checks only when DEMUX_CNT_EN is defined.
module tb_demux4_stream_v1;

    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    in_sel;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [W-1:0]  out_data;
    logic          busy;
`ifdef DEMUX_CNT_EN
    logic [4*CW-1:0] cnt_out;
`endif

    demux4_stream_v1 #(
        .width    (W),
        .cnt_width(CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
`ifdef DEMUX_CNT_EN
        ,
        .cnt_out  (cnt_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: beats accepted but not yet delivered, plus delivered
    // counts per port.
    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   sel;
    } beat_t;

    beat_t q[$];
    int    delivered[4];

    always @(negedge clk) begin
        logic [3:0] exp_ov;
        logic       exp_ir;
        beat_t      b;
        if (!rst_n) begin
            q.delete();
            for (int k = 0; k < 4; k++) delivered[k] = 0;
            chk("rst_out_valid", 64'(out_valid), 64'h0);
            chk("rst_busy", 64'(busy), 64'h0);
            chk("rst_in_ready", 64'(in_ready), 64'h0);
        end else begin
            exp_ov = 4'b0000;
            exp_ir = 1'b1;
            if (q.size() != 0) begin
                exp_ov[q[0].sel] = 1'b1;
                exp_ir = out_ready[q[0].sel];
            end
            chk("sb_out_valid", 64'(out_valid), 64'(exp_ov));
            chk("sb_busy", 64'(busy), 64'(q.size() != 0));
            chk("sb_in_ready", 64'(in_ready), 64'(exp_ir));
            if (q.size() != 0)
                chk("sb_out_data", 64'(out_data), 64'(q[0].data));
`ifdef DEMUX_CNT_EN
            for (int k = 0; k < 4; k++) begin
                int e;
                e = (delivered[k] > 15) ? 15 : delivered[k];
                chk("sb_cnt", 64'(cnt_out[k*CW +: CW]), 64'(e));
            end
`endif
            // What the coming rising edge does.
            if (q.size() != 0 && out_ready[q[0].sel]) begin
                delivered[q[0].sel]++;
                void'(q.pop_front());
            end
            if (in_valid && exp_ir) begin
                b.data = in_data;
                b.sel  = in_sel;
                q.push_back(b);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic send(input logic [W-1:0] d, input logic [1:0] s);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at 0 want 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_data  = 32'hBAD0BAD0;
        in_sel   = 2'd3;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0] one;
        int         c0;
        one       = 4'b0001;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = 4'b1111;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        chk("reset_out_data", 64'(out_data), 64'h0);
        chk("reset_in_ready", 64'(in_ready), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_reset_in_ready", 64'(in_ready), 64'h1);

        // Single beat to port 2.
        send(32'hDEADBEEF, 2'd2);
        chk("t1_out_valid", 64'(out_valid), 64'h4);
        chk("t1_out_data", 64'(out_data), 64'hDEADBEEF);
        chk("t1_busy", 64'(busy), 64'h1);
        idle(1);
        chk("t1_empty", 64'(busy), 64'h0);
        idle(1);

        // Backpressure on port 1, with a second beat waiting upstream.
        out_ready = 4'b0000;
        send(32'hA5A5_0001, 2'd1);
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        in_sel   = 2'd0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 64'(out_valid), 64'h2);
            chk("bp_out_data", 64'(out_data), 64'hA5A5_0001);
            chk("bp_in_ready", 64'(in_ready), 64'h0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 4'b0010;
        @(posedge clk);
        #1;
        chk("bp_done_busy", 64'(busy), 64'h0);
        chk("bp_done_valid", 64'(out_valid), 64'h0);

        // Streaming 8 beats, rotating destination, all ready.
        out_ready = 4'b1111;
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            send(32'(i), 2'(i % 4));
            chk("st_out_valid", 64'(out_valid), 64'(one << (i % 4)));
            chk("st_out_data", 64'(out_data), 64'(i));
        end
        chk("st_cycles", 64'(cyc - c0), 64'd8);
        idle(2);

        // Ready only on the wrong ports.
        out_ready = 4'b0000;
        send(32'hCAFE_0003, 2'd3);
        in_valid  = 1'b0;
        out_ready = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            chk("wp_out_valid", 64'(out_valid), 64'h8);
            chk("wp_in_ready", 64'(in_ready), 64'h0);
            @(posedge clk);
            #1;
        end
        out_ready = 4'b1000;
        @(posedge clk);
        #1;
        chk("wp_done_busy", 64'(busy), 64'h0);
        idle(1);

        // Asynchronous reset while holding a beat for port 0.
        out_ready = 4'b0000;
        send(32'h0BAD_F00D, 2'd0);
        in_valid = 1'b0;
        chk("mr_pre_valid", 64'(out_valid), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", 64'(out_valid), 64'h0);
        chk("mr_busy", 64'(busy), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 4'b1111;
        idle(1);
        chk("mr_after_valid", 64'(out_valid), 64'h0);

`ifdef DEMUX_CNT_EN
        for (int i = 0; i < 20; i++) send(32'(100 + i), 2'd2);
        for (int i = 0; i < 3; i++) send(32'(200 + i), 2'd0);
        idle(2);
        chk("cnt_port2", 64'(cnt_out[2*CW +: CW]), 64'hF);
        chk("cnt_port0", 64'(cnt_out[0 +: CW]), 64'h3);
        chk("cnt_port1", 64'(cnt_out[1*CW +: CW]), 64'h0);
        chk("cnt_port3", 64'(cnt_out[3*CW +: CW]), 64'h0);
`endif

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1);
    end

endmodule
